// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, FSM encoding and Rcon lookup
package aes_pkg;
   localparam int NR = 10;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EXPAND = 2'd1;
   localparam logic [1:0] ST_EMIT   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;
   // Rcon[1..10]; index 0 is never a legal step and returns 0
   function automatic logic [7:0] rcon_byte(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box, out_o = affine(in_i^-1 in GF(2^8))
// Ports: in_i [7:0] input byte, out_o [7:0] substituted byte
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction
   logic [7:0] x2, x3, x12, x15, x240, inv;
   // inverse as x^254 via an addition chain; 0 maps to 0 naturally
   always_comb begin
      x2   = gmul(in_i, in_i);
      x3   = gmul(x2, in_i);
      x12  = gmul(gmul(x3, x3), gmul(x3, x3));
      x15  = gmul(x12, x3);
      x240 = gmul(x15, x15);
      x240 = gmul(x240, x240);
      x240 = gmul(x240, x240);
      x240 = gmul(x240, x240);
      inv  = gmul(gmul(x240, x12), x2);
      out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

// File: rtl/aes_key_sched_rev.sv
// aes_key_sched_rev: AES-128 round-key generator streaming keys in encrypt or decrypt order
// Ports: clk/rst_n clock and async active-low reset; start/mode/key_in request a schedule;
//        rk_out/rk_round/rk_valid with rk_ready form the key stream; busy/done report status
module aes_key_sched_rev
   import aes_pkg::*;
#(
   parameter int NR = aes_pkg::NR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         mode,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   output logic         busy,
   output logic         done
);
   logic [1:0]   state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   round_q, round_d;
   logic         mode_q, mode_d;
   logic [31:0]  a0, a1, a2, a3, p1, p2, p3, sub_in, rot, sub_out, rcon;
   logic [127:0] step;
   logic         fwd, last;
   assign {a0, a1, a2, a3} = key_q;
   // expansion always runs forward; emission runs in the requested direction
   assign fwd    = (state_q == ST_EXPAND) || mode_q;
   assign p3     = a3 ^ a2;
   assign p2     = a2 ^ a1;
   assign p1     = a1 ^ a0;
   // both step directions share one SubWord, fed with a3 (forward) or recovered p3 (reverse)
   assign sub_in = fwd ? a3 : p3;
   assign rot    = {sub_in[23:0], sub_in[31:24]};
   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (.in_i(rot[8*i +: 8]), .out_o(sub_out[8*i +: 8]));
   end
   assign rcon = {rcon_byte(fwd ? round_q + 4'd1 : round_q), 24'h0};
   always_comb begin
      logic [31:0] n0;
      n0   = a0 ^ sub_out ^ rcon;
      step = fwd ? {n0, a1 ^ n0, a2 ^ a1 ^ n0, a3 ^ a2 ^ a1 ^ n0} : {n0, p1, p2, p3};
   end
   assign last = mode_q ? (round_q == 4'(NR)) : (round_q == 4'd0);
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: if (start) begin
            key_d   = key_in;
            round_d = 4'd0;
            mode_d  = mode;
            state_d = mode ? ST_EMIT : ST_EXPAND;
         end
         ST_EXPAND: begin
            key_d   = step;
            round_d = round_q + 4'd1;
            state_d = (round_q == 4'(NR - 1)) ? ST_EMIT : ST_EXPAND;
         end
         ST_EMIT: if (rk_ready) begin
            state_d = last ? ST_DONE : ST_EMIT;
            key_d   = last ? key_q : step;
            round_d = last ? round_q : (mode_q ? round_q + 4'd1 : round_q - 4'd1);
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         round_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         mode_q  <= mode_d;
      end
   end
   assign rk_out   = key_q;
   assign rk_round = round_q;
   assign rk_valid = (state_q == ST_EMIT);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_aes_key_sched_rev.sv
// tb_aes_key_sched_rev: directed FIPS-197 key-schedule vectors against aes_key_sched_rev
module tb_aes_key_sched_rev;
   logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, mode = 1'b0, rk_ready = 1'b0;
   logic [127:0] key_in = '0;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         rk_valid, busy, done;
   int n_vec = 0, n_err = 0;
   logic [127:0] rk_tab [0:10] = '{
      128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
      128'ha0fafe17_88542cb1_23a33939_2a6c7605,
      128'hf2c295f2_7a96b943_5935807a_7359f67f,
      128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
      128'hef44a541_a8525b7f_b671253b_db0bad00,
      128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
      128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
      128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
      128'head27321_b58dbad2_312bf560_7f8d292f,
      128'hac7766f3_19fadc21_28d12941_575c006e,
      128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
   };
   aes_key_sched_rev dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in),
      .rk_ready(rk_ready), .rk_out(rk_out), .rk_round(rk_round),
      .rk_valid(rk_valid), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // one full schedule; tog drops rk_ready every other cycle, inject pulses start mid-EMIT
   task automatic run(input logic m, input bit tog, input bit inject, input int first_lat, input int done_lat);
      int idx = 0, cyc = 1, r;
      bit seen = 0, fin = 0;
      @(negedge clk);
      start = 1'b1; mode = m; key_in = rk_tab[0]; rk_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_run", busy, 1);
      while (!fin && cyc < 80) begin
         rk_ready = tog ? cyc[0] : 1'b1;
         start    = inject && cyc == 3;
         key_in   = inject ? 128'hdeadbeef_0badf00d_12345678_9abcdef0 : key_in;
         if (rk_valid) begin
            if (!seen) begin
               seen = 1;
               chk("first_lat", 128'(cyc), 128'(first_lat));
            end
            r = m ? idx : 10 - idx;
            chk("rk_out", rk_out, (r >= 0 && r <= 10) ? rk_tab[r] : 'x);
            chk("rk_round", 128'(rk_round), 128'(r));
            if (rk_ready) idx++;
         end
         if (done) begin
            if (done_lat >= 0) chk("done_lat", 128'(cyc), 128'(done_lat));
            chk("n_keys", 128'(idx), 128'd11);
            fin = 1;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!fin) chk("timeout", 128'd0, 128'd1);
      chk("done_pulse", done, 0);
      chk("busy_end", busy, 0);
   endtask
   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out", rk_out, 0);
      chk("rst_valid", {rk_valid, busy, done, rk_round}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(1'b1, 1'b0, 1'b0, 1, 12);
      run(1'b0, 1'b0, 1'b0, 11, 22);
      run(1'b0, 1'b1, 1'b0, 11, -1);
      run(1'b1, 1'b0, 1'b1, 1, 12);
      // reset in the fifth EXPAND cycle
      @(negedge clk);
      start = 1'b1; mode = 1'b0; key_in = rk_tab[0];
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy_expand", {busy, rk_valid}, 2'b10);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out", rk_out, 0);
      chk("midrst_flags", {rk_valid, busy, done, rk_round}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {rk_valid, busy, done}, 0);
      run(1'b0, 1'b0, 1'b0, 11, 22);
      // all-zero key, encrypt
      @(negedge clk);
      start = 1'b1; mode = 1'b1; key_in = '0; rk_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_r0", rk_out, 0);
      @(negedge clk);
      chk("zero_r1", rk_out, 128'h62636363_62636363_62636363_62636363);
      chk("zero_r1_idx", 128'(rk_round), 128'd1);
      for (int i = 0; i < 30 && !done; i++) @(negedge clk);
      chk("zero_done", done, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/aes_key_sched_rev.md
AES_KEY_SCHED_REV -- requirements
Module: aes_key_sched_rev

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES-128 rounds; only 10 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a new schedule; sampled only in IDLE.
REQ-005 SHALL have port mode  input  1  1 = encrypt order (round 0 to 10), 0 = decrypt order (round 10 to 0); sampled with start.
REQ-006 SHALL have port key_in  input  128  cipher key, sampled with start; column-major, word w0 = key_in[127:96].
REQ-007 SHALL have port rk_ready  input  1  downstream consumer accepts rk_out.
REQ-008 SHALL have port rk_out  output  128  current round key, same byte ordering as key_in.
REQ-009 SHALL have port rk_round  output  4  round index of rk_out (0..10).
REQ-010 SHALL have port rk_valid  output  1  rk_out and rk_round are valid.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the final key is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, EXPAND, EMIT, DONE.
REQ-014 IDLE: start=1 SHALL load key_in into the key register, set round=0, and go to EMIT if mode=1, or to EXPAND if mode=0.
REQ-015 EXPAND SHALL apply one forward step per cycle for exactly 10 cycles (round 0 to 10), then go to EMIT with round=10; rk_valid SHALL stay 0 throughout.
REQ-016 Forward step SHALL be: n0=a0^SubWord(RotWord(a3))^Rcon[r+1]; n1=a1^n0; n2=a2^n1; n3=a3^n2.
REQ-017 Reverse step SHALL be: p3=a3^a2; p2=a2^a1; p1=a1^a0; p0=a0^SubWord(RotWord(p3))^Rcon[r].
REQ-018 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36, placed in byte [31:24] of the word.
REQ-019 EMIT SHALL assert rk_valid with rk_out = key register and rk_round = round counter.
REQ-020 While rk_valid=1 and rk_ready=0, rk_out and rk_round SHALL hold stable.
REQ-021 On rk_valid&rk_ready: if the last round has been reached (10 in encrypt order, 0 in decrypt order), go to DONE; otherwise apply a forward step (encrypt) or a reverse step (decrypt) and increment or decrement the round counter accordingly.
REQ-022 Handshake throughput SHALL be one key per cycle while rk_ready stays high.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 start SHALL be ignored while busy=1; start in the same cycle as the DONE pulse SHALL be ignored.
REQ-025 Latency from start accepted in cycle T: first rk_valid at T+1 (encrypt) or T+11 (decrypt).
REQ-026 rk_out SHALL be registered; rk_valid, busy and done SHALL be decoded from registered state only.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, rk_out=0, rk_round=0, rk_valid=0, busy=0, done=0, regardless of the current state.
REQ-028 Reset mid-schedule SHALL discard the key; no partial schedule resumes after reset is released.

Structure
REQ-029 The shared package aes_pkg SHALL hold the Rcon table, the FSM state encoding, and NR.
REQ-030 SubWord SHALL use four instances of the combinational sub-module aes_sbox (8-bit in, 8-bit out), shared by the forward and reverse paths.

Verification
REQ-031 Encrypt order, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1 -> round 0 = key; round 1 = a0fafe17_88542cb1_23a33939_2a6c7605; round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6; done at T+12.
REQ-032 Decrypt order, same key -> first rk_valid at T+11 with round 10 = d014f9a8...; round 1 = a0fafe17...; round 0 = 2b7e1516...; 11 keys in consecutive cycles.
REQ-033 Decrypt order, rk_ready toggling every other cycle -> each key held stable until accepted; the sequence is identical to REQ-032.
REQ-034 start pulsed during EMIT with a different key -> ignored; the output sequence is unchanged.
REQ-035 rst_n asserted during EXPAND cycle 5 -> all outputs 0 immediately; a new start after reset gives the full correct sequence.
REQ-036 All-zero key, encrypt -> round 1 = 62636363_62636363_62636363_62636363.
